cache_miss_sequencer: RTL and testbench
=======================================

Name: cache_miss_sequencer

Overview:
- Multi-port L1 miss/refill sequencer. Serves NUM_PORTS L1 caches, for example I-cache and D-cache, over one shared main-memory channel.
- Acks hits on all ports in parallel and arbitrates misses round-robin.
- For a miss: writes back a dirty victim word by word, then refills the line word by word straight into the requesting L1.
- An internal word counter replaces the external cache-line buffer and its full flag. A watchdog aborts stalled memory transfers.

Parameters:
- NUM_PORTS, 2, number of L1 request ports (>=1).
- WORDS_PER_LINE, 8, words per cache line (power of 2, >=2).
- TIMEOUT, 0, max cycles waiting on mem_valid_mm per word; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req  in  NUM_PORTS  port i has a read or write pending (level, held until ack).
- hit  in  NUM_PORTS  port i lookup hits.
- dirty  in  NUM_PORTS  port i victim line is dirty.
- mem_valid_mm  in  1  main memory accepted (write) or returned (read) the current word this cycle.
- clr  out  1  L1 invalidate-all pulse.
- ack  out  NUM_PORTS  port i request completed this cycle.
- sel_port  out  $clog2(NUM_PORTS) or 1  port owning the current transfer.
- word_idx  out  $clog2(WORDS_PER_LINE)  word offset of the current transfer.
- re_victim  out  1  read victim word word_idx from L1[sel_port].
- we_l1  out  NUM_PORTS  write returned word word_idx into L1 i.
- re_mm  out  1  main-memory read request.
- we_mm  out  1  main-memory write request.
- busy  out  1  miss sequence in progress.
- err_timeout  out  1  sticky; set on watchdog expiry, cleared only by reset.

Behaviour:
- Reset: state=INIT; word counter, watchdog and rr pointer reset to 0; err_timeout=0.
- All outputs are combinational from the state and default to 0, except as listed per state.
- Reset asserted mid-transfer aborts immediately with no further mm/L1 strobes. The partially filled line is invalidated by the clr pulse in INIT.
- INIT: clr=1 for exactly one cycle, then IDLE.
- IDLE:
  - ack[i]=req[i]&hit[i] for all i, same cycle (zero-latency hit).
  - miss=req&~hit. If nonzero, the winner p is the first set bit at or after rr_ptr, wrapping.
  - Latch p into sel_port and set rr_ptr <= p+1 (mod NUM_PORTS).
  - Next state is WRITEBACK if dirty[p], else FETCH. Word counter cleared.
  - Hits on other ports in the same cycle are still acked.
- WRITEBACK:
  - busy=1, we_mm=1, re_victim=1, word_idx=cnt.
  - On mem_valid_mm: cnt++. On the last word (cnt==WORDS_PER_LINE-1 & mem_valid_mm): cnt<=0, go to FETCH.
- FETCH:
  - busy=1, re_mm=1, word_idx=cnt, we_l1[p]=mem_valid_mm. Each returned word is written the cycle it arrives.
  - On the last word: go to IDLE.
  - Port p then hits on re-lookup and is acked in IDLE, at least 1 cycle after the last word.
- While busy: ack=0 for all ports; hits on non-owning ports stall.
- Dropping req[p] mid-sequence does not abort it; the line completes.
- Watchdog (TIMEOUT>0):
  - Counts consecutive WRITEBACK/FETCH cycles without mem_valid_mm; it is cleared on each mem_valid_mm and on state entry.
  - Reaching TIMEOUT sets err_timeout and goes to INIT; the clr pulse invalidates the partial line.
- Word counter: width $clog2(WORDS_PER_LINE). The last word is detected by compare, not by wrap.
- Cost: miss-to-ack latency is at least WORDS_PER_LINE+1 cycles (clean) or 2*WORDS_PER_LINE+1 (dirty) with mem_valid_mm held high.
- Illegal or unreachable state encodings go to INIT.

Decomposition:
- Package cache_ctrl_pkg: state enum {INIT, IDLE, WRITEBACK, FETCH}; localparams for the port-index and word-index widths.
- Sub-module rr_arbiter (parameter N): request vector + pointer in, one-hot grant and index out.

Test Plan:
- NUM_PORTS=2. req=2'b11, hit=2'b11 in IDLE -> ack=2'b11 the same cycle; busy=0, no mm strobes.
- Clean miss, WORDS_PER_LINE=4, port1, mem_valid_mm every other cycle:
  - re_mm high 8 cycles; word_idx 0..3; we_l1=2'b10 on each valid.
  - Returns to IDLE; ack[1] once hit=1.
- Dirty miss, port0, mem_valid_mm held high, WORDS=4:
  - we_mm+re_victim for 4 cycles with word_idx 0..3.
  - Then re_mm for 4 cycles with we_l1[0]=1; ack[0] at cycle 9.
- Both ports miss every IDLE visit with rr_ptr=0 -> grants alternate 0,1,0,1.
- Same stimulus with rr_ptr=1 -> port1 is granted first.
- TIMEOUT=5, FETCH with mem_valid_mm=0 -> after 5 cycles err_timeout=1 (sticky), clr pulse, then IDLE.
- Reset at word 2 of FETCH -> next cycle all strobes 0, clr=1, cnt=0, rr_ptr=0.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared state encoding and index-width helpers for the L1 miss/refill sequencer.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT      = 2'd0,
    IDLE      = 2'd1,
    WRITEBACK = 2'd2,
    FETCH     = 2'd3
  } state_t;

  // Index width that stays at least 1 bit for single-entry vectors.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_PORTS      = 2;
  localparam int DEF_WORDS_PER_LINE = 8;
  localparam int PORT_W             = idx_w(DEF_NUM_PORTS);
  localparam int WORD_W             = idx_w(DEF_WORDS_PER_LINE);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping; purely combinational.
module rr_arbiter
  import cache_ctrl_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic [N-1:0]          grant,
  output logic [idx_w(N)-1:0]   idx,
  output logic                  vld
);

  localparam int IW = idx_w(N);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    vld   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!vld && req[j]) begin
        vld      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cache_miss_sequencer.sv
// Multi-port L1 miss sequencer: zero-latency hit acks, round-robin miss service,
// dirty writeback then refill over one memory channel; stalls only on mem_valid_mm.
module cache_miss_sequencer
  import cache_ctrl_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int WORDS_PER_LINE = 8,
  parameter int TIMEOUT        = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              req,
  input  logic [NUM_PORTS-1:0]              hit,
  input  logic [NUM_PORTS-1:0]              dirty,
  input  logic                              mem_valid_mm,
  output logic                              clr,
  output logic [NUM_PORTS-1:0]              ack,
  output logic [idx_w(NUM_PORTS)-1:0]       sel_port,
  output logic [$clog2(WORDS_PER_LINE)-1:0] word_idx,
  output logic                              re_victim,
  output logic [NUM_PORTS-1:0]              we_l1,
  output logic                              re_mm,
  output logic                              we_mm,
  output logic                              busy,
  output logic                              err_timeout
);

  localparam int PW = idx_w(NUM_PORTS);
  localparam int WW = $clog2(WORDS_PER_LINE);
  localparam int TW = idx_w(TIMEOUT + 1);

  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS_PER_LINE - 1);
  localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);
  localparam logic [TW-1:0] WD_LIMIT  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t               state, state_nxt;
  logic [WW-1:0]        cnt;
  logic [TW-1:0]        wdog;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        owner;
  logic [NUM_PORTS-1:0] miss;
  logic [NUM_PORTS-1:0] gnt;
  logic [PW-1:0]        gnt_idx;
  logic                 gnt_vld;
  logic                 xfer;
  logic                 last_word;
  logic                 wd_expire;

  assign miss = req & ~hit;

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .req   (miss),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .vld   (gnt_vld)
  );

  assign xfer      = (state == WRITEBACK) || (state == FETCH);
  assign last_word = (cnt == LAST_WORD);
  // Fires on the TIMEOUT-th consecutive stalled transfer cycle.
  assign wd_expire = (TIMEOUT > 0) && xfer && !mem_valid_mm && (wdog == WD_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT: state_nxt = IDLE;
      IDLE: begin
        if (gnt_vld) state_nxt = (|(dirty & gnt)) ? WRITEBACK : FETCH;
      end
      WRITEBACK: begin
        if (wd_expire)                     state_nxt = INIT;
        else if (mem_valid_mm && last_word) state_nxt = FETCH;
      end
      FETCH: begin
        if (wd_expire)                     state_nxt = INIT;
        else if (mem_valid_mm && last_word) state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      rr_ptr      <= '0;
      owner       <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (gnt_vld) begin
            owner  <= gnt_idx;
            rr_ptr <= (gnt_idx == LAST_PORT) ? '0 : gnt_idx + PW'(1);
          end
        end
        WRITEBACK, FETCH: begin
          if (mem_valid_mm) cnt <= last_word ? '0 : cnt + WW'(1);
        end
        default: cnt <= '0;
      endcase
      if (wd_expire) err_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      wdog <= '0;
    else if (TIMEOUT == 0 || !xfer || mem_valid_mm || state_nxt != state)
      wdog <= '0;
    else
      wdog <= wdog + TW'(1);
  end

  always_comb begin
    clr       = 1'b0;
    ack       = '0;
    sel_port  = '0;
    word_idx  = '0;
    re_victim = 1'b0;
    we_l1     = '0;
    re_mm     = 1'b0;
    we_mm     = 1'b0;
    busy      = 1'b0;
    case (state)
      INIT: clr = 1'b1;
      IDLE: ack = req & hit;
      WRITEBACK: begin
        busy      = 1'b1;
        we_mm     = 1'b1;
        re_victim = 1'b1;
        sel_port  = owner;
        word_idx  = cnt;
      end
      FETCH: begin
        busy     = 1'b1;
        re_mm    = 1'b1;
        sel_port = owner;
        word_idx = cnt;
        we_l1    = mem_valid_mm ? (NUM_PORTS'(1) << owner) : '0;
      end
      default: clr = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Randomized bench for cache_miss_sequencer against a transaction-level reference model.
module tb_cache_miss_sequencer;

  localparam int NP = 2;
  localparam int W  = 4;
  localparam int TO = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req, hit, dirty;
  logic       mem_valid_mm;
  logic       clr;
  logic [1:0] ack;
  logic       sel_port;
  logic [1:0] word_idx;
  logic       re_victim;
  logic [1:0] we_l1;
  logic       re_mm, we_mm, busy, err_timeout;

  always #5 clk = ~clk;

  cache_miss_sequencer #(.NUM_PORTS(NP), .WORDS_PER_LINE(W), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .hit          (hit),
    .dirty        (dirty),
    .mem_valid_mm (mem_valid_mm),
    .clr          (clr),
    .ack          (ack),
    .sel_port     (sel_port),
    .word_idx     (word_idx),
    .re_victim    (re_victim),
    .we_l1        (we_l1),
    .re_mm        (re_mm),
    .we_mm        (we_mm),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  int   n_chk = 0;
  int   n_bad = 0;
  int   exp_rr = 0;
  logic exp_err = 1'b0;

  logic [12:0] obs;
  assign obs = {clr, ack, sel_port, word_idx, re_victim, we_l1, re_mm, we_mm, busy, err_timeout};

  function automatic logic [12:0] pk(input logic c, input logic [1:0] a, input logic s,
                                     input logic [1:0] w, input logic rv, input logic [1:0] wl,
                                     input logic rm, input logic wm, input logic b, input logic e);
    return {c, a, s, w, rv, wl, rm, wm, b, e};
  endfunction

  function automatic int pick(input logic [1:0] m, input int rr);
    for (int k = 0; k < NP; k++) begin
      int j;
      j = (rr + k) % NP;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] rq, input logic [1:0] hi,
                       input logic [1:0] dt, input logic mv);
    reset = rst; req = rq; hit = hi; dirty = dt; mem_valid_mm = mv;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic [1:0] rq, input logic [1:0] hi, input logic [1:0] dt,
                            input string tag);
    drive(1'b0, rq, hi, dt, 1'b0);
    chk(tag, 32'(obs), 32'(pk(0, rq & hi, 0, 2'd0, 0, 2'd0, 0, 0, 0, exp_err)));
    tick();
  endtask

  // mode: 0 valid every cycle, 1 valid every other cycle, 2 random, 3 never valid
  task automatic do_miss(input logic [1:0] rq, input logic [1:0] hi, input logic [1:0] dt,
                         input int mode, input string tag);
    int p, done_wb, done_f, stall, cyc;
    logic wb, mv, abort;
    logic [1:0] r;
    logic [12:0] exp;
    p = pick(rq & ~hi, exp_rr);
    idle_cycle(rq, hi, dt, {tag, "-idle"});
    if (p < 0) return;
    exp_rr = (p + 1) % NP;
    wb = dt[p];
    done_wb = 0; done_f = 0; stall = 0; cyc = 0;
    while (1) begin
      case (mode)
        0:       mv = 1'b1;
        1:       mv = (cyc % 2) == 1;
        2:       mv = $urandom_range(0, 99) < 70;
        default: mv = 1'b0;
      endcase
      drive(1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), mv);
      if (wb && done_wb < W)
        exp = pk(0, 2'd0, p[0], done_wb[1:0], 1, 2'd0, 0, 1, 1, exp_err);
      else
        exp = pk(0, 2'd0, p[0], done_f[1:0], 0, mv ? 2'(1 << p) : 2'd0, 1, 0, 1, exp_err);
      chk({tag, "-xfer"}, 32'(obs), 32'(exp));
      abort = 1'b0;
      if (mv) begin
        if (wb && done_wb < W) done_wb++;
        else                   done_f++;
        stall = 0;
      end else begin
        stall++;
        if (stall == TO) abort = 1'b1;
      end
      tick();
      cyc++;
      if (abort) begin
        exp_err = 1'b1;
        drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        chk({tag, "-abort-clr"}, 32'(obs), 32'(pk(1, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0, 0, exp_err)));
        tick();
        return;
      end
      if (done_f == W) break;
      if (cyc > 200) begin
        chk({tag, "-budget"}, 32'(cyc), 32'd200);
        return;
      end
    end
    r = 2'(1 << p);
    idle_cycle(r, r, 2'd0, {tag, "-ack"});
  endtask

  initial begin
    int p;
    logic [12:0] exp;
    drive(1'b1, 2'd0, 2'd0, 2'd0, 1'b0);
    tick();
    chk("reset-state", 32'(obs), 32'(pk(1, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0)));
    tick();
    drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    chk("init-clr", 32'(obs), 32'(pk(1, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0)));
    tick();
    idle_cycle(2'b00, 2'b00, 2'b00, "idle-quiet");

    idle_cycle(2'b11, 2'b11, 2'b00, "hit-both");
    idle_cycle(2'b11, 2'b01, 2'b00, "hit-p0-miss-p1");
    // The cycle above granted port 1 on a clean miss; finish that line first.
    drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    chk("grant-p1", 32'(sel_port), 32'd1);
    for (int k = 0; k < W; k++) begin
      drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b1);
      chk("quick-fill", 32'(obs), 32'(pk(0, 2'd0, 1, 2'(k), 0, 2'b10, 1, 0, 1, 0)));
      tick();
    end
    exp_rr = 0;
    idle_cycle(2'b10, 2'b10, 2'b00, "quick-ack");

    do_miss(2'b10, 2'b00, 2'b00, 1, "clean-p1");
    do_miss(2'b01, 2'b00, 2'b01, 0, "dirty-p0");
    for (int k = 0; k < 4; k++) do_miss(2'b11, 2'b00, 2'b00, 0, "rr-from1");
    do_miss(2'b10, 2'b00, 2'b00, 0, "to-rr0");
    for (int k = 0; k < 4; k++) do_miss(2'b11, 2'b00, 2'($urandom_range(0, 3)), 0, "rr-from0");

    do_miss(2'b01, 2'b00, 2'b00, 3, "timeout");
    idle_cycle(2'b00, 2'b00, 2'b00, "err-sticky");
    do_miss(2'b11, 2'b00, 2'b11, 0, "after-timeout");

    // Reset landing on word 2 of a refill.
    p = pick(2'b11, exp_rr);
    idle_cycle(2'b11, 2'b00, 2'b00, "rst-mid-idle");
    for (int k = 0; k < 3; k++) begin
      drive(k == 2, 2'd0, 2'd0, 2'd0, 1'b1);
      exp = pk(0, 2'd0, p[0], 2'(k), 0, 2'(1 << p), 1, 0, 1, exp_err);
      chk("rst-mid-fetch", 32'(obs), 32'(exp));
      tick();
    end
    exp_rr = 0;
    exp_err = 1'b0;
    drive(1'b0, 2'd0, 2'd0, 2'd0, 1'b1);
    chk("rst-mid-clr", 32'(obs), 32'(pk(1, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0)));
    tick();
    do_miss(2'b11, 2'b00, 2'b00, 0, "rr-after-reset");

    for (int k = 0; k < 30; k++)
      do_miss(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2, "rand");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global-timeout: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

endmodule
